// File: rtl/neuron_accumulator_pkg.sv
// Shared widths, state encoding and the output saturation helper
// for the neuron accumulator.
package neuron_accumulator_pkg;

    localparam int PSUM_W       = 20;
    localparam int ACC_W        = 26;
    localparam int ACT_W        = 8;
    localparam int SUM_W        = ACC_W + 1;
    localparam int CNT_W        = 7;
    localparam int DEF_PIPE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        OUT
    } state_t;

    function automatic logic [ACT_W-1:0] sat_act(
        input logic [SUM_W-1:0] s,
        input int               shift
    );
        logic [SUM_W-1:0] t;
        t = s >> shift;
        return (t > SUM_W'(255)) ? '1 : t[ACT_W-1:0];
    endfunction

endpackage

// File: rtl/neuron_accumulator_valid.sv
// Alignment line that delays the feeder's valid strobe to match
// the adder-tree latency.
module valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(d);
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates adder-tree partial sums over one neuron, adds bias,
// then scales and saturates to an 8-bit activation.
module neuron_accumulator
    import neuron_accumulator_pkg::*;
#(
    parameter int NUM_CHUNKS = 49,
    parameter int PIPE_LAT   = DEF_PIPE_LAT,
    parameter int OUT_SHIFT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PSUM_W-1:0] sumout,
    input  logic [ACC_W-1:0]  bias,
    output logic [ACT_W-1:0]  act_out,
    output logic              act_valid,
    output logic              busy,
    output logic              err_extra
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum27;
    logic [ACT_W-1:0] act_q;
    logic             pv;

    valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (in_valid),
        .q   (pv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum27     <= '0;
            act_q     <= '0;
            err_extra <= 1'b0;
        end else begin
            if (pv && state != ACCUM) begin
                err_extra <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (pv) begin
                        acc <= acc + ACC_W'(sumout);
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(NUM_CHUNKS - 1)) begin
                            state <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    sum27 <= {1'b0, acc} + {1'b0, bias};
                    state <= OUT;
                end
                OUT: begin
                    act_q <= sat_act(sum27, OUT_SHIFT);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The result is presented during OUT and then held in act_q.
    assign act_out   = (state == OUT) ? sat_act(sum27, OUT_SHIFT) : act_q;
    assign act_valid = (state == OUT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized bench: per-cycle checks of all outputs against a
// neuron-level arithmetic model and an upstream latency model.
module tb_neuron_accumulator;

    localparam int NUM = 49;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] sumout = '0;
    logic [25:0] bias = '0;
    logic [7:0]  act_out;
    logic        act_valid;
    logic        busy;
    logic        err_extra;

    neuron_accumulator #(
        .NUM_CHUNKS (NUM),
        .PIPE_LAT   (3),
        .OUT_SHIFT  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .sumout    (sumout),
        .bias      (bias),
        .act_out   (act_out),
        .act_valid (act_valid),
        .busy      (busy),
        .err_extra (err_extra)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_cyc = -10;
    int          done_cyc = -10;
    int          err_from = 0;
    bit          err_armed = 0;
    bit          chk_en = 0;
    logic [7:0]  exp_act = '0;
    logic [7:0]  last_act = '0;
    bit          hv [0:3];
    logic [19:0] hd [0:3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic step(input bit r, input bit st, input bit iv,
                        input logic [19:0] v);
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(cyc > start_cyc && cyc <= done_cyc));
            chk("act_valid", 32'(act_valid), 32'(cyc == done_cyc));
            chk("act_out", 32'(act_out),
                32'((cyc == done_cyc) ? exp_act : last_act));
            chk("err_extra", 32'(err_extra),
                32'(err_armed && cyc >= err_from));
        end
        if (cyc == done_cyc) last_act = exp_act;
        if (r) begin
            start_cyc = -10;
            done_cyc  = -10;
            last_act  = '0;
            err_armed = 0;
        end
        rst      = r;
        start    = st;
        in_valid = iv;
        for (int i = 3; i > 0; i--) begin
            hv[i] = hv[i-1];
            hd[i] = hd[i-1];
        end
        hv[0]  = iv;
        hd[0]  = v;
        sumout = hv[3] ? hd[3] : 20'($urandom);
    endtask

    function automatic logic [19:0] gen(input int kind);
        if (kind == 0) return 20'd16;
        if (kind == 1) return 20'd1040400;
        return 20'($urandom_range(0, 2600));
    endfunction

    task automatic run_neuron(input int kind, input logic [25:0] b,
                              input int gmax, input bit same,
                              input bit extra, input bit ign);
        longint      total;
        longint      sh;
        int          n;
        logic [19:0] v;
        bias  = b;
        total = longint'(b);
        n     = 0;
        if (same) begin
            v = gen(kind);
            step(0, 1, 1, v);
            total += longint'(v);
            n = 1;
        end else begin
            step(0, 1, 0, '0);
        end
        start_cyc = cyc;
        done_cyc  = 1 << 30;
        while (n < NUM) begin
            repeat ($urandom_range(0, gmax)) step(0, 0, 0, '0);
            v = gen(kind);
            step(0, ign && n == 10, 1, v);
            total += longint'(v);
            n++;
        end
        done_cyc = cyc + 5;
        sh       = total >> 8;
        exp_act  = (sh > 255) ? 8'd255 : 8'(sh);
        if (extra) begin
            step(0, 0, 1, gen(kind));
            if (!err_armed) err_from = cyc + 4;
            err_armed = 1;
        end
        while (cyc < done_cyc) step(0, 0, 0, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            hv[i] = 0;
            hd[i] = '0;
        end
        repeat (3) step(1, 0, 0, '0);
        chk_en = 1;
        repeat (3) step(0, 0, 0, '0);

        run_neuron(0, 26'd0, 0, 0, 0, 0);
        run_neuron(0, 26'd256, 0, 0, 0, 0);
        run_neuron(1, 26'd0, 0, 0, 0, 0);
        run_neuron(2, 26'($urandom_range(0, 20000)), 3, 1, 0, 0);
        run_neuron(2, 26'($urandom_range(0, 20000)), 3, 1, 0, 0);
        step(0, 0, 0, '0);
        run_neuron(2, 26'($urandom_range(0, 20000)), 1, 0, 1, 1);
        repeat (4) step(0, 0, 0, '0);
        run_neuron(2, 26'($urandom_range(0, 20000)), 2, 1, 0, 0);

        step(0, 1, 1, gen(2));
        start_cyc = cyc;
        done_cyc  = 1 << 30;
        repeat (10) step(0, 0, 1, gen(2));
        repeat (2) step(1, 0, 0, '0);
        repeat (3) step(0, 0, 0, '0);
        run_neuron(2, 26'($urandom_range(0, 20000)), 2, 0, 0, 0);

        for (int k = 0; k < 4; k++) begin
            run_neuron(2, 26'($urandom_range(0, 60000)),
                       $urandom_range(0, 3), 1'($urandom), 0, 0);
        end
        repeat (3) step(0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Downstream consumer of the 16-lane multiply/adder-tree stage. It accumulates the stage's 20-bit partial sums over all chunks of one neuron (NUM_CHUNKS × 16 pixel/weight pairs) and adds a per-neuron bias. It then scales and saturates the total to an 8-bit activation and presents it with a one-cycle valid pulse. The block tracks the adder-tree's fixed 3-cycle latency internally, so the upstream feeder only marks the cycles in which it drives pixels/weights.

## Interface
- NUM_CHUNKS, 49, chunks per neuron (784 inputs / 16 lanes); legal range 1..64
- PIPE_LAT, 3, cycles from feeder driving pixels/weights to matching `sumout` being valid
- OUT_SHIFT, 8, right shift applied to (acc + bias) before saturation
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new neuron; honoured only in IDLE
- in_valid  in  1  high in the cycle the feeder drives a chunk into the adder-tree stage
- sumout  in  20  unsigned partial sum from the adder-tree stage
- bias  in  26  unsigned bias; sampled on the BIAS cycle, must be held from `start` until `act_valid`
- act_out  out  8  saturated activation; holds its value until the next result
- act_valid  out  1  one-cycle pulse, `act_out` valid
- busy  out  1  high in ACCUM, BIAS and OUT
- err_extra  out  1  sticky; an aligned chunk arrived outside ACCUM

## Operation
- Valid delay line: shift register of PIPE_LAT bits, runs in every state. Its output `pv` marks the cycles in which `sumout` belongs to a chunk.
- State machine: IDLE, ACCUM, BIAS, OUT.
  - IDLE: when `start` is high, go to ACCUM, with acc ← 0 and cnt ← 0.
  - ACCUM: when `pv` is high, acc ← acc + sumout and cnt ← cnt + 1. When `pv` is high with cnt = NUM_CHUNKS−1, go to BIAS.
  - BIAS: sum27 ← acc + bias (27-bit), registered. Go to OUT.
  - OUT: act_out ← (sum27 >> OUT_SHIFT > 255) ? 255 : sum27[OUT_SHIFT+7:OUT_SHIFT]. act_valid ← 1. Go to IDLE.
- Width rules: all arithmetic is unsigned. acc is 26 bits; the worst case 49 × 1,040,400 = 50,979,600 fits, so no overflow is possible within the legal NUM_CHUNKS range.
- `start` outside IDLE: ignored.
- `pv` in IDLE, BIAS or OUT: chunk dropped, acc unchanged, err_extra ← 1.
- Feeder rule: the first `in_valid` of a neuron must occur no earlier than the cycle in which `start` is asserted. `start` and the first `in_valid` in the same cycle is legal.
- Back-to-back neurons: the next `start` is legal in the cycle after `act_valid` (state IDLE).
- Reset (at any time, including mid-neuron): state = IDLE, acc = 0, cnt = 0, delay line = 0, act_out = 0, act_valid = 0, busy = 0, err_extra = 0. Chunks in flight are discarded.

## Timing
- `in_valid` in cycle c gives `pv` high and matching `sumout` in cycle c+PIPE_LAT (c+3). That chunk is added at the end of c+3.
- For the last chunk, issued in cycle c: BIAS is in c+4 and act_valid is high in c+5.
- Latency from the last `in_valid` to `act_valid` is PIPE_LAT+2 = 5 cycles.
- `start` in cycle s gives busy high from s+1.
- busy falls in the cycle after act_valid.
- act_valid is never high for two consecutive cycles.
- Gaps between `in_valid` cycles are allowed. Accumulation order is irrelevant.

## Structure
- Shared package holds:
  - PSUM_W = 20, ACC_W = 26, ACT_W = 8
  - default PIPE_LAT = 3 (must match the adder-tree stage's register count)
  - state encoding enum {IDLE, ACCUM, BIAS, OUT}
- One sub-module, `valid_delay` (parameter DEPTH, synchronous reset, 1-bit in/out), implements the PIPE_LAT alignment line.
- FSM, counter, accumulator and saturation logic live in `neuron_accumulator`.

## Test plan
- All pixels = 1, weights = 1, 49 chunks, bias = 0 → sumout 16 per chunk, acc = 784, act_out = 3, act_valid exactly 5 cycles after the last in_valid.
- Same stimulus, bias = 256 → sum27 = 1040, act_out = 4.
- All pixels = 255, weights = 255, 49 chunks, bias = 0 → acc = 50,979,600, act_out saturates to 255, err_extra = 0.
- `start` in the same cycle as the first in_valid, in_valid gaps of 0–3 random cycles, then a second neuron started the cycle after act_valid → both results correct, busy profile as specified.
- 50 in_valid pulses for NUM_CHUNKS = 49 → result uses the first 49 only, err_extra = 1 and stays high. A `start` pulse during ACCUM is ignored.
- rst asserted mid-ACCUM, with chunks in the delay line, then a fresh neuron → all outputs 0 after reset, no stale chunk added, fresh result correct.
